// File: rtl/uart_frame_recv_if.sv
// Byte-in / frame-out bundle for the UART frame assembler.
// The master drives enable and the byte strobe; the slave returns frame outputs.
interface uart_frame_recv_if #(
    parameter int BYTE_N = 4
);
    logic                  en;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic [8*BYTE_N-1:0]   data;
    logic                  wren;
    logic                  err_timeout;
    logic                  err_chk;
    logic                  busy;

    modport master (
        output en,
        output byte_valid,
        output byte_data,
        input  data,
        input  wren,
        input  err_timeout,
        input  err_chk,
        input  busy
    );

    modport slave (
        input  en,
        input  byte_valid,
        input  byte_data,
        output data,
        output wren,
        output err_timeout,
        output err_chk,
        output busy
    );
endinterface

// File: rtl/uart_frame_recv.sv
// UART frame assembler: header hunt, payload collect, inter-byte timeout.
// Optional trailing checksum byte is compiled in with UART_FRAME_CHK_EN.
module uart_frame_recv #(
    parameter int         BYTE_N      = 4,
    parameter bit         MSB_FIRST   = 1'b1,
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_frame_recv_if.slave  bus
);

    localparam int DW = 8 * BYTE_N;
    localparam int CW = (BYTE_N > 1) ? $clog2(BYTE_N) : 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(BYTE_N - 1);
    localparam logic [TW-1:0] TMO_CNT  = TW'(TIMEOUT_CYC - 1);

`ifdef UART_FRAME_CHK_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1
    } state_t;
`endif

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_tcnt;
    logic [DW-1:0]   r_shadow;
    logic [DW-1:0]   r_data;
    logic            r_wren;
    logic            r_err_tmo;
    logic            r_busy;
`ifdef UART_FRAME_CHK_EN
    logic [7:0]      r_sum;
    logic            r_err_chk;
`endif

    logic            w_last;
    logic            w_tmo;
    logic [CW-1:0]   w_slot;
    logic [DW-1:0]   w_shadow_nxt;

    assign w_last = (r_cnt == LAST_CNT);
    assign w_tmo  = (r_tcnt == TMO_CNT);
    assign w_slot = MSB_FIRST ? (LAST_CNT - r_cnt) : r_cnt;

    // Shadow register with the incoming byte dropped into its slot.
    always_comb begin
        w_shadow_nxt = r_shadow;
        for (int i = 0; i < BYTE_N; i++) begin
            if (w_slot == CW'(i)) begin
                w_shadow_nxt[8*i +: 8] = bus.byte_data;
            end
        end
    end

    // Frame FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tcnt    <= '0;
            r_shadow  <= '0;
            r_data    <= '0;
            r_wren    <= 1'b0;
            r_err_tmo <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_FRAME_CHK_EN
            r_sum     <= '0;
            r_err_chk <= 1'b0;
`endif
        end else begin
            r_wren    <= 1'b0;
            r_err_tmo <= 1'b0;
`ifdef UART_FRAME_CHK_EN
            r_err_chk <= 1'b0;
`endif
            if (!bus.en) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_tcnt  <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_tcnt <= '0;
                        if (bus.byte_valid && bus.byte_data == HEADER) begin
                            r_state <= S_PAYLOAD;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
`ifdef UART_FRAME_CHK_EN
                            r_sum   <= '0;
`endif
                        end
                    end
                    S_PAYLOAD: begin
                        if (bus.byte_valid) begin
                            r_shadow <= w_shadow_nxt;
                            r_tcnt   <= '0;
                            r_cnt    <= r_cnt + CW'(1);
`ifdef UART_FRAME_CHK_EN
                            r_sum    <= r_sum + bus.byte_data;
                            if (w_last) begin
                                r_state <= S_CHECK;
                            end
`else
                            if (w_last) begin
                                r_data  <= w_shadow_nxt;
                                r_wren  <= 1'b1;
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
`endif
                        end else if (w_tmo) begin
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                            r_tcnt    <= '0;
                            r_err_tmo <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
`ifdef UART_FRAME_CHK_EN
                    S_CHECK: begin
                        if (bus.byte_valid) begin
                            r_tcnt  <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (bus.byte_data == r_sum) begin
                                r_data <= r_shadow;
                                r_wren <= 1'b1;
                            end else begin
                                r_err_chk <= 1'b1;
                            end
                        end else if (w_tmo) begin
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                            r_tcnt    <= '0;
                            r_err_tmo <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_tcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.data        = r_data;
    assign bus.wren        = r_wren;
    assign bus.err_timeout = r_err_tmo;
    assign bus.busy        = r_busy;
`ifdef UART_FRAME_CHK_EN
    assign bus.err_chk     = r_err_chk;
`else
    assign bus.err_chk     = 1'b0;
`endif

endmodule

// File: doc/uart_frame_recv.md
# uart_frame_recv

Parametrised UART frame assembler that sits directly behind the byte-level UART receiver. It hunts for a header byte, collects a fixed number of payload bytes into a wide word in a selectable byte order, and aborts stalled frames with an inter-byte timeout. An optional checksum byte can be compiled in. It outputs a single-cycle write strobe and only ever presents complete, validated frames.

## Interface
- BYTE_N, 4: payload bytes per frame, ≥1
- MSB_FIRST, 1: 1 = first payload byte lands in data[8*BYTE_N-1 -: 8]; 0 = first byte lands in data[7:0]
- HEADER, 8'hA5: sync byte that opens a frame
- TIMEOUT_CYC, 50000: maximum clk cycles between accepted bytes inside a frame, ≥2
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  receive enable; low forces IDLE and ignores bytes
- byte_valid  input  1  one-cycle strobe from the byte receiver
- byte_data  input  8  received byte, valid with byte_valid
- data  output  8*BYTE_N  last good frame payload; updates only on wren
- wren  output  1  one-cycle pulse, frame complete
- err_timeout  output  1  one-cycle pulse, frame aborted by timeout
- err_chk  output  1  one-cycle pulse, checksum mismatch (0 when the checksum feature is compiled out)
- busy  output  1  high while state ≠ IDLE

## Operation
- Reset values: state IDLE; data, wren, err_timeout, err_chk, busy, shadow register, byte counter, timeout counter and checksum all 0.
- IDLE: byte_valid with byte_data==HEADER → PAYLOAD, counter=0, sum=0. Any other byte is ignored.
- PAYLOAD: each byte_valid writes byte_data into the shadow register at slot cnt, ordered per MSB_FIRST, and adds it to sum mod 256. The HEADER value is treated as ordinary data here. On the byte with cnt==BYTE_N-1: go to CHECK if the checksum feature is enabled, otherwise commit.
- CHECK: the next byte_valid is compared with sum. On a match, commit. On a mismatch, pulse err_chk, leave data unchanged, and go to IDLE.
- Commit: data ← shadow register (including the final byte), pulse wren, go to IDLE.
- Timeout counter: clears on every accepted byte and on entering a non-IDLE state, and increments each cycle outside IDLE. When it reaches TIMEOUT_CYC-1 with no byte_valid: go to IDLE and pulse err_timeout.
- en low in any state: go to IDLE next cycle with no error pulse and no commit. data is held.
- Counter widths are $clog2(BYTE_N) and $clog2(TIMEOUT_CYC), with a minimum of 1.

## Timing
- wren and the new data are registered: both appear in the cycle after the byte_valid of the last frame byte (payload byte, or checksum byte when the checksum feature is enabled).
- err_chk and err_timeout are registered single-cycle pulses and are mutually exclusive with wren.
- byte_valid and timeout expiry in the same cycle: the byte wins and the counter clears.
- byte_valid in the cycle after commit/abort is seen in IDLE, so back-to-back frames are supported.
- rst_n asserted mid-frame: all state clears immediately and the partial frame is discarded.

## Configuration
- UART_FRAME_CHK_EN defined: the CHECK state exists, each frame carries a trailing 8-bit checksum equal to the sum mod 256 of its payload bytes, and err_chk is active.
- UART_FRAME_CHK_EN undefined: there is no CHECK state, frames end after the last payload byte, and err_chk is tied to 0.

## Test plan
- BYTE_N=4, MSB_FIRST=1, checksum off: bytes A5 11 22 33 44 → data=32'h11223344, wren high for 1 cycle, one cycle after the 44 strobe.
- MSB_FIRST=0, same stream → data=32'h44332211.
- Bytes 00 FF A5 A5 01 02 03 → leading 00 and FF are ignored, the second A5 is payload, data=32'hA5010203.
- Checksum on: A5 01 02 03 04 0A → wren, data=32'h01020304. A5 01 02 03 04 0B → err_chk pulse, no wren, data unchanged.
- TIMEOUT_CYC=100: A5 11 followed by a 100-cycle gap → err_timeout pulse, busy low. A following frame A5 .. is accepted normally.
- en dropped after A5 11 22 → busy low next cycle, no pulses. rst_n asserted mid-frame → all outputs 0.
